// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter that shares one combinational FP ALU between requesters
// and returns tagged results through a stallable, registered pipeline.
module fp_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [1:0]            alu_op,
  input  logic [31:0]           alu_out,
  input  logic                  alu_gt,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [TAG_W-1:0]      resp_tag,
  output logic [31:0]           resp_data,
  output logic                  resp_gt,
  output logic                  busy
);

  localparam int NRES = LATENCY - 1;

  typedef struct packed {
    logic             v;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } iss_t;

  typedef struct packed {
    logic             v;
    logic [31:0]      data;
    logic             gt;
    logic [TAG_W-1:0] tag;
  } res_t;

  iss_t             iss_q, iss_d;
  res_t             res_q [NRES];
  res_t             res_d [NRES];
  logic [TAG_W-1:0] ptr_q, ptr_d;

  logic             advance;
  logic             xfer;
  logic             gnt_found;
  logic [TAG_W-1:0] gnt_idx;

  function automatic logic [TAG_W-1:0] wrap(input int x);
    return TAG_W'(x % NUM_REQ);
  endfunction

  assign advance = !res_q[NRES-1].v || resp_ready;

  // search starts one past the last winner
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && req_valid[wrap(int'(ptr_q) + k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap(int'(ptr_q) + k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && advance && gnt_found)
      req_ready[gnt_idx] = 1'b1;
  end

  assign xfer = rst_n && advance && gnt_found;

  always_comb begin
    iss_d = iss_q;
    ptr_d = ptr_q;
    res_d = res_q;
    if (advance) begin
      iss_d.v = xfer;
      if (xfer) begin
        iss_d.a   = req_a[32*gnt_idx +: 32];
        iss_d.b   = req_b[32*gnt_idx +: 32];
        iss_d.op  = req_op[2*gnt_idx +: 2];
        iss_d.tag = gnt_idx;
        ptr_d     = gnt_idx;
      end
      res_d[0].v    = iss_q.v;
      res_d[0].data = alu_out;
      res_d[0].gt   = alu_gt && (iss_q.op == 2'b11);
      res_d[0].tag  = iss_q.tag;
      for (int s = 1; s < NRES; s++)
        res_d[s] = res_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q <= '0;
      ptr_q <= TAG_W'(NUM_REQ - 1);
      for (int s = 0; s < NRES; s++)
        res_q[s] <= '0;
    end else begin
      iss_q <= iss_d;
      ptr_q <= ptr_d;
      res_q <= res_d;
    end
  end

  assign alu_a      = iss_q.a;
  assign alu_b      = iss_q.b;
  assign alu_op     = iss_q.op;
  assign resp_valid = res_q[NRES-1].v;
  assign resp_tag   = res_q[NRES-1].tag;
  assign resp_data  = res_q[NRES-1].data;
  assign resp_gt    = res_q[NRES-1].gt;

  always_comb begin
    busy = iss_q.v;
    for (int s = 0; s < NRES; s++)
      busy = busy | res_q[s].v;
  end

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Bench for fp_alu_arbiter: stub FP ALU, directed requests,
// queue scoreboard checked by an independent response monitor.
module tb_fp_alu_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [7:0]   req_op;
  logic [31:0]  alu_a, alu_b, alu_out;
  logic [1:0]   alu_op;
  logic         alu_gt;
  logic         resp_valid, resp_ready;
  logic [1:0]   resp_tag;
  logic [31:0]  resp_data;
  logic         resp_gt, busy;

  always #5 clk = ~clk;

  fp_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_gt(alu_gt),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_tag(resp_tag), .resp_data(resp_data),
    .resp_gt(resp_gt), .busy(busy)
  );

  // stub ALU: table of the operand pairs used here; gt ignores op
  function automatic logic [32:0] fp_model(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [1:0] op);
    logic [31:0] r;
    case ({op, a, b})
      {2'b00, 32'h3FC00000, 32'h40200000}: r = 32'h40800000;
      {2'b00, 32'h40200000, 32'h3FC00000}: r = 32'h40800000;
      {2'b00, 32'h3FC00000, 32'h3FC00000}: r = 32'h40400000;
      {2'b01, 32'h40200000, 32'h3FC00000}: r = 32'h3F800000;
      {2'b10, 32'h40400000, 32'h40000000}: r = 32'h40C00000;
      default:                             r = 32'h7FC00000;
    endcase
    if (op == 2'b11) r = b;
    return {r, a > b};
  endfunction

  always_comb {alu_out, alu_gt} = fp_model(alu_a, alu_b, alu_op);

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
    logic        gt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         gnt_log[$];
  logic [3:0] xfer_n = '0;
  logic       hold = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    xfer_n <= req_valid & req_ready;
    if (rst_n) begin
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      if ((req_valid & req_ready) != 4'b0)
        gnt_log.push_back(oh_idx(req_valid & req_ready));
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: got tag %0d data %h expected none",
                   resp_tag, resp_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_tag", 32'(resp_tag), 32'(mon_e.tag));
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_gt", 32'(resp_gt), 32'(mon_e.gt));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!hold) req_valid = req_valid & ~xfer_n;
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[2*i +: 2]  = op;
  endtask

  task automatic push(input logic [1:0] tag, input logic [31:0] data,
                      input logic gt);
    exp_q.push_back('{tag: tag, data: data, gt: gt});
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    chk({name, "_drain_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic load_all4();
    set_op(0, 32'h40200000, 32'h3FC00000, 2'b01);
    set_op(1, 32'h40400000, 32'h40000000, 2'b10);
    set_op(2, 32'h40200000, 32'h3FC00000, 2'b11);
    set_op(3, 32'h3FC00000, 32'h3FC00000, 2'b00);
  endtask

  task automatic push_all4();
    push(2'd0, 32'h3F800000, 1'b0);
    push(2'd1, 32'h40C00000, 1'b0);
    push(2'd2, 32'h3FC00000, 1'b1);
    push(2'd3, 32'h40400000, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    int c;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;

    // reset state, all four already requesting
    load_all4();
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", 32'(resp_tag), 0);
    chk("rst_resp_gt", 32'(resp_gt), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", 32'(alu_op), 0);

    // all four back-to-back
    push_all4();
    gnt_log.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("all4_first_ready", 32'(req_ready), 32'h1);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("all4_busy", 32'(busy), 1);
      step();
    end
    drain("all4", 10);
    chk("all4_gnt_cnt", 32'(gnt_log.size()), 4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++)
      chk("all4_gnt", 32'(gnt_log[i]), 32'(i));

    // single op latency
    set_op(0, 32'h3FC00000, 32'h40200000, 2'b00);
    push(2'd0, 32'h40800000, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    step();
    @(negedge clk);
    chk("single_early_valid", 32'(resp_valid), 0);
    chk("single_busy", 32'(busy), 1);
    chk("single_alu_a", alu_a, 32'h3FC00000);
    chk("single_alu_b", alu_b, 32'h40200000);
    chk("single_alu_op", 32'(alu_op), 0);
    step();
    @(negedge clk);
    chk("single_valid", 32'(resp_valid), 1);
    chk("single_tag", 32'(resp_tag), 0);
    drain("single", 5);

    // fairness with req1 and req3 held
    gnt_log.delete();
    set_op(1, 32'h40400000, 32'h40000000, 2'b10);
    set_op(3, 32'h3FC00000, 32'h3FC00000, 2'b00);
    for (int i = 0; i < 3; i++) begin
      push(2'd1, 32'h40C00000, 1'b0);
      push(2'd3, 32'h40400000, 1'b0);
    end
    hold = 1'b1;
    req_valid = 4'b1010;
    g = 0;
    c = 0;
    while (g < 6 && c < 20) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 4'b0) g++;
      step();
      c++;
    end
    req_valid = '0;
    hold = 1'b0;
    chk("fair_grants", 32'(g), 6);
    drain("fair", 10);
    chk("fair_gnt_cnt", 32'(gnt_log.size()), 6);
    for (int i = 0; i < gnt_log.size() && i < 6; i++)
      chk("fair_gnt", 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

    // gt masking
    set_op(2, 32'h40200000, 32'h3FC00000, 2'b00);
    push(2'd2, 32'h40800000, 1'b0);
    req_valid = 4'b0100;
    drain("gt_add", 10);
    set_op(2, 32'h40200000, 32'h3FC00000, 2'b11);
    push(2'd2, 32'h3FC00000, 1'b1);
    req_valid = 4'b0100;
    drain("gt_cmp", 10);

    // backpressure with three requests
    resp_ready = 1'b0;
    set_op(0, 32'h3FC00000, 32'h40200000, 2'b00);
    set_op(1, 32'h40200000, 32'h3FC00000, 2'b01);
    set_op(2, 32'h40200000, 32'h3FC00000, 2'b11);
    push(2'd0, 32'h40800000, 1'b0);
    push(2'd1, 32'h3F800000, 1'b0);
    push(2'd2, 32'h3FC00000, 1'b1);
    req_valid = 4'b0111;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 1);
      chk("stall_tag", 32'(resp_tag), 0);
      chk("stall_data", resp_data, 32'h40800000);
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_alu_a", alu_a, 32'h40200000);
      chk("stall_alu_op", 32'(alu_op), 32'h1);
      chk("stall_busy", 32'(busy), 1);
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'h4);
    chk("rel_valid0", 32'(resp_valid), 1);
    step();
    @(negedge clk);
    chk("rel_valid1", 32'(resp_valid), 1);
    step();
    @(negedge clk);
    chk("rel_valid2", 32'(resp_valid), 1);
    step();
    @(negedge clk);
    chk("rel_no_dup", 32'(resp_valid), 0);
    drain("bp", 5);

    // reset with two ops in flight
    set_op(0, 32'h3FC00000, 32'h40200000, 2'b00);
    set_op(1, 32'h40200000, 32'h3FC00000, 2'b01);
    req_valid = 4'b0011;
    step();
    step();
    load_all4();
    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(resp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    push_all4();
    gnt_log.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(req_ready), 32'h1);
    step();
    drain("postrst", 15);
    chk("postrst_gnt_cnt", 32'(gnt_log.size()), 4);
    if (gnt_log.size() > 0)
      chk("postrst_first_gnt", 32'(gnt_log[0]), 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
